lift_ctrl_scan: RTL

Parametrised N-floor elevator controller, next generation of the 4-floor elevator FSM. Latches hall-up, hall-down and car calls into pending-request vectors, serves them with a SCAN (collective) policy, and drives motor direction and door with programmable travel and dwell times. Sits between the button/request front end and the motor/door drivers; replaces the fixed 4-floor FSM plus its input buffer.

---
 rtl/lift_pkg.sv | 26 ++
 rtl/lift_req_bank.sv | 64 ++++++
 rtl/lift_ctrl_scan.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// Shared encodings for the SCAN elevator controller: motor codes, FSM states,
// travel direction and the per-floor request reduction flags.
package lift_pkg;
  localparam logic [1:0] UP   = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] STAY = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  typedef struct packed {
    logic above;
    logic below;
    logic car_at;
    logic up_at;
    logic dn_at;
  } req_flags_t;

  function automatic dir_t dir_flip(input dir_t d);
    return (d == DIR_UP) ? DIR_DN : DIR_UP;
  endfunction

  function automatic logic [1:0] dir_motor(input dir_t d);
    return (d == DIR_UP) ? UP : DOWN;
  endfunction
endpackage

// File: rtl/lift_req_bank.sv
// Pending hall-up/hall-down/car request registers with set suppression at the
// open door and above/below/at-floor reductions relative to a query floor.
module lift_req_bank
  import lift_pkg::*;
#(
  parameter  int FLOORS = 4,
  localparam int FLR_W  = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] hall_up_req,
  input  logic [FLOORS-1:0] hall_dn_req,
  input  logic [FLOORS-1:0] car_req,
  input  logic              door,
  input  dir_t              dir,
  input  logic [FLR_W-1:0]  qfloor,
  input  logic [FLOORS-1:0] clr_up,
  input  logic [FLOORS-1:0] clr_dn,
  input  logic [FLOORS-1:0] clr_car,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_dn,
  output logic [FLOORS-1:0] pend_car,
  output req_flags_t        flags,
  output logic              hold_hit
);
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0] f_oh, any_p, hu, hd, sup_up, sup_dn, sup_car;

  assign f_oh    = {{(FLOORS-1){1'b0}}, 1'b1} << qfloor;
  assign hu      = hall_up_req & UP_OK;
  assign hd      = hall_dn_req & DN_OK;
  // While the door is open, calls the open car already serves are absorbed.
  assign sup_car = door ? f_oh : '0;
  assign sup_up  = (door && dir == DIR_UP) ? f_oh : '0;
  assign sup_dn  = (door && dir == DIR_DN) ? f_oh : '0;
  assign hold_hit = |((hu & sup_up) | (hd & sup_dn) | (car_req & sup_car));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_up  <= '0;
      pend_dn  <= '0;
      pend_car <= '0;
    end else begin
      pend_up  <= (pend_up  | (hu & ~sup_up))       & ~clr_up;
      pend_dn  <= (pend_dn  | (hd & ~sup_dn))       & ~clr_dn;
      pend_car <= (pend_car | (car_req & ~sup_car)) & ~clr_car;
    end
  end

  assign any_p = pend_up | pend_dn | pend_car;

  always_comb begin
    flags        = '0;
    flags.car_at = |(pend_car & f_oh);
    flags.up_at  = |(pend_up & f_oh);
    flags.dn_at  = |(pend_dn & f_oh);
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(qfloor)) flags.above = flags.above | any_p[i];
      if (i < int'(qfloor)) flags.below = flags.below | any_p[i];
    end
  end
endmodule

// File: rtl/lift_ctrl_scan.sv
// N-floor SCAN elevator controller: IDLE/MOVE/DOOR FSM with travel and dwell
// timers, driving motor direction and door from latched requests.
module lift_ctrl_scan
  import lift_pkg::*;
#(
  parameter  int FLOORS     = 4,
  parameter  int TRAVEL_CYC = 4,
  parameter  int DOOR_CYC   = 3,
  localparam int FLR_W      = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] hall_up_req,
  input  logic [FLOORS-1:0] hall_dn_req,
  input  logic [FLOORS-1:0] car_req,
  output logic [1:0]        motor,
  output logic              door_open,
  output logic [FLR_W-1:0]  floor,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_dn,
  output logic [FLOORS-1:0] pend_car,
  output logic              busy
);
  localparam int TC_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DC_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TC_W-1:0]  T_LOAD = TC_W'(TRAVEL_CYC - 1);
  localparam logic [DC_W-1:0]  D_LOAD = DC_W'(DOOR_CYC - 1);
  localparam logic [TC_W-1:0]  T_ONE  = TC_W'(1);
  localparam logic [DC_W-1:0]  D_ONE  = DC_W'(1);
  localparam logic [FLR_W-1:0] F_ONE  = FLR_W'(1);

  state_t            state;
  dir_t              dir, stop_dir, door_dir;
  logic [TC_W-1:0]   tcnt;
  logic [DC_W-1:0]   dcnt;
  logic [FLR_W-1:0]  qfloor;
  logic [FLOORS-1:0] q_oh, clr_up, clr_dn, clr_car;
  req_flags_t        fl;
  logic              hold_hit, ahead, behind, at_any, arrive_stop, door_enter, c_up, c_dn;

  lift_req_bank #(.FLOORS(FLOORS)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .hall_up_req (hall_up_req),
    .hall_dn_req (hall_dn_req),
    .car_req     (car_req),
    .door        (state == DOOR),
    .dir         (dir),
    .qfloor      (qfloor),
    .clr_up      (clr_up),
    .clr_dn      (clr_dn),
    .clr_car     (clr_car),
    .pend_up     (pend_up),
    .pend_dn     (pend_dn),
    .pend_car    (pend_car),
    .flags       (fl),
    .hold_hit    (hold_hit)
  );

  // In MOVE the flags are evaluated at the floor being arrived at.
  always_comb begin
    qfloor = floor;
    if (state == MOVE) qfloor = (dir == DIR_UP) ? floor + F_ONE : floor - F_ONE;
  end

  always_comb begin
    ahead       = (dir == DIR_UP) ? fl.above : fl.below;
    behind      = (dir == DIR_UP) ? fl.below : fl.above;
    at_any      = fl.car_at | fl.up_at | fl.dn_at;
    arrive_stop = fl.car_at | ((dir == DIR_UP) ? fl.up_at : fl.dn_at) | !ahead;
    stop_dir    = (state == MOVE && !ahead) ? dir_flip(dir) : dir;
    door_dir    = stop_dir;
    c_up        = 1'b0;
    c_dn        = 1'b0;
    if (stop_dir == DIR_UP) begin
      if (fl.up_at) c_up = 1'b1;
      else if (fl.dn_at) begin c_dn = 1'b1; door_dir = DIR_DN; end
    end else begin
      if (fl.dn_at) c_dn = 1'b1;
      else if (fl.up_at) begin c_up = 1'b1; door_dir = DIR_UP; end
    end
    door_enter = (state == IDLE && at_any) ||
                 (state == MOVE && tcnt == '0 && arrive_stop);
    q_oh    = {{(FLOORS-1){1'b0}}, 1'b1} << qfloor;
    clr_car = door_enter ? q_oh : '0;
    clr_up  = (door_enter && c_up) ? q_oh : '0;
    clr_dn  = (door_enter && c_dn) ? q_oh : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      floor     <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      motor     <= STAY;
      door_open <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (at_any) begin
            state <= DOOR; dir <= door_dir; dcnt <= D_LOAD; door_open <= 1'b1; motor <= STAY;
          end else if (ahead) begin
            state <= MOVE; tcnt <= T_LOAD; motor <= dir_motor(dir);
          end else if (behind) begin
            state <= MOVE; tcnt <= T_LOAD; dir <= dir_flip(dir); motor <= dir_motor(dir_flip(dir));
          end
        end
        MOVE: begin
          if (tcnt == '0) begin
            floor <= qfloor;
            if (arrive_stop) begin
              state <= DOOR; dir <= door_dir; dcnt <= D_LOAD; door_open <= 1'b1; motor <= STAY;
            end else begin
              tcnt <= T_LOAD;
            end
          end else begin
            tcnt <= tcnt - T_ONE;
          end
        end
        DOOR: begin
          if (hold_hit) dcnt <= D_LOAD;
          else if (dcnt == '0) begin state <= IDLE; door_open <= 1'b0; end
          else dcnt <= dcnt - D_ONE;
        end
        default: begin
          state <= IDLE; motor <= STAY; door_open <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE) || (|{pend_up, pend_dn, pend_car});
endmodule
